// File: rtl/tx_symbol_source.sv
// Test-symbol source for the TX pulse shaper: PRBS / impulse / constant dibits, Gray-mapped to 1s17, upsampled by UPS.
// Outputs registered one cycle after the phase-0 edge; enable low freezes everything, no backpressure otherwise.
module tx_symbol_source #(
  parameter int UPS  = 4,
  parameter int HOLD = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [1:0]         const_sel,
  input  logic               seed_load,
  input  logic [14:0]        seed,
  output logic signed [17:0] sym_out,
  output logic               sym_strobe,
  output logic [1:0]         bits_out,
  output logic [15:0]        sym_count
);

  typedef enum logic [1:0] {
    ST_PRBS    = 2'd0,
    ST_IMPULSE = 2'd1,
    ST_CONST   = 2'd2
  } state_t;

  localparam logic [3:0] PHASE_LAST = 4'(UPS - 1);

  state_t             state_q, state_d;
  logic [14:0]        lfsr_q, lfsr_d;
  logic [3:0]         phase_q, phase_d;
  logic               armed_q, armed_d;
  logic signed [17:0] sym_out_q, sym_out_d;
  logic signed [17:0] last_q, last_d;
  logic               strobe_q, strobe_d;
  logic [1:0]         bits_q, bits_d;
  logic [15:0]        count_q, count_d;

  logic [14:0]        lfsr_src;
  logic [14:0]        lfsr_s1;
  logic [14:0]        lfsr_s2;
  logic [1:0]         prbs_bits;
  logic [1:0]         sym_bits;
  logic signed [17:0] sym_level;
  state_t             mode_state;

  function automatic logic signed [17:0] map_level(input logic [1:0] b);
    logic signed [17:0] v;
    case (b)
      2'b00:   v = 18'sh20000;  // -131072
      2'b01:   v = 18'sh35556;  // -43690
      2'b11:   v = 18'sh0AAAA;  // +43690
      default: v = 18'sh1FFFF;  // +131071
    endcase
    return v;
  endfunction

  function automatic state_t decode_mode(input logic [1:0] m);
    state_t s;
    case (m)
      2'b01:   s = ST_IMPULSE;
      2'b10:   s = ST_CONST;
      default: s = ST_PRBS;
    endcase
    return s;
  endfunction

  // A seed load replaces the shift source, so a load on a phase-0 cycle feeds that symbol's two shifts.
  always_comb begin
    lfsr_src  = seed_load ? ((seed == 15'd0) ? 15'h0001 : seed) : lfsr_q;
    lfsr_s1   = {lfsr_src[13:0], lfsr_src[14] ^ lfsr_src[13]};
    lfsr_s2   = {lfsr_s1[13:0], lfsr_s1[14] ^ lfsr_s1[13]};
    prbs_bits = {lfsr_s1[0], lfsr_s2[0]};
  end

  always_comb begin
    mode_state = decode_mode(mode);
    sym_bits   = 2'b00;
    sym_level  = '0;
    lfsr_d     = lfsr_src;
    phase_d    = phase_q;
    state_d    = state_q;
    armed_d    = armed_q;
    sym_out_d  = sym_out_q;
    last_d     = last_q;
    strobe_d   = 1'b0;
    bits_d     = bits_q;
    count_d    = count_q;

    if (enable) begin
      phase_d = (phase_q == PHASE_LAST) ? 4'd0 : phase_q + 4'd1;
      if (phase_q == 4'd0) begin
        state_d = mode_state;
        case (mode_state)
          ST_IMPULSE: begin
            armed_d = 1'b0;
            if (armed_q) begin
              sym_bits  = 2'b10;
              sym_level = map_level(2'b10);
            end
          end
          ST_CONST: begin
            armed_d   = 1'b1;
            sym_bits  = const_sel;
            sym_level = map_level(const_sel);
          end
          default: begin
            armed_d   = 1'b1;
            lfsr_d    = lfsr_s2;
            sym_bits  = prbs_bits;
            sym_level = map_level(prbs_bits);
          end
        endcase
        sym_out_d = sym_level;
        last_d    = sym_level;
        bits_d    = sym_bits;
        strobe_d  = 1'b1;
        count_d   = count_q + 16'd1;
      end else begin
        sym_out_d = (HOLD != 0) ? last_q : 18'sd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_PRBS;
      lfsr_q    <= 15'h0001;
      phase_q   <= 4'd0;
      armed_q   <= 1'b1;
      sym_out_q <= '0;
      last_q    <= '0;
      strobe_q  <= 1'b0;
      bits_q    <= 2'b00;
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      phase_q   <= phase_d;
      armed_q   <= armed_d;
      sym_out_q <= sym_out_d;
      last_q    <= last_d;
      strobe_q  <= strobe_d;
      bits_q    <= bits_d;
      count_q   <= count_d;
    end
  end

  assign sym_out    = sym_out_q;
  assign sym_strobe = strobe_q;
  assign bits_out   = bits_q;
  assign sym_count  = count_q;

endmodule

// File: tb/tb_tx_symbol_source.sv
// Bench for tx_symbol_source: three instances (UPS=1, UPS=4, UPS=4 HOLD=1) checked every cycle against an arithmetic model.
module tb_tx_symbol_source;

  logic        clk = 1'b0;
  logic        reset, enable, seed_load;
  logic [1:0]  mode, const_sel;
  logic [14:0] seed;

  logic signed [17:0] so [3];
  logic               ss [3];
  logic [1:0]         sb [3];
  logic [15:0]        sc [3];

  localparam int UPS_T  [3] = '{1, 4, 4};
  localparam int HOLD_T [3] = '{0, 0, 1};

  always #5 clk = ~clk;

  tx_symbol_source #(.UPS(1), .HOLD(0)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .const_sel(const_sel),
    .seed_load(seed_load), .seed(seed),
    .sym_out(so[0]), .sym_strobe(ss[0]), .bits_out(sb[0]), .sym_count(sc[0]));
  tx_symbol_source #(.UPS(4), .HOLD(0)) u4 (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .const_sel(const_sel),
    .seed_load(seed_load), .seed(seed),
    .sym_out(so[1]), .sym_strobe(ss[1]), .bits_out(sb[1]), .sym_count(sc[1]));
  tx_symbol_source #(.UPS(4), .HOLD(1)) u4h (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .const_sel(const_sel),
    .seed_load(seed_load), .seed(seed),
    .sym_out(so[2]), .sym_strobe(ss[2]), .bits_out(sb[2]), .sym_count(sc[2]));

  // Model state, one slot per instance
  int m_lfsr [3];
  int m_en   [3];
  int m_out  [3];
  int m_last [3];
  int m_stb  [3];
  int m_bits [3];
  int m_cnt  [3];
  bit m_imp  [3];

  int n_cmp = 0;
  int n_bad = 0;
  int imp_seen = 0;
  bit chk_on = 1'b0;
  int lit_sel = 0;
  int lit_k = 0;
  int lit_a = 0;

  function automatic int level_of(input int b);
    case (b)
      0:       return -131072;
      1:       return -43690;
      3:       return 43690;
      default: return 131071;
    endcase
  endfunction

  function automatic int next_bit(input int s);
    return ((s >> 14) ^ (s >> 13)) & 1;
  endfunction

  task automatic model_step(input int i);
    int src, b1, b2, md, l;
    if (reset) begin
      m_lfsr[i] = 1; m_en[i] = 0; m_out[i] = 0; m_last[i] = 0;
      m_stb[i] = 0; m_bits[i] = 0; m_cnt[i] = 0; m_imp[i] = 1'b0;
    end else begin
      src = seed_load ? ((seed == 15'd0) ? 1 : int'(seed)) : m_lfsr[i];
      m_stb[i] = 0;
      if (enable) begin
        if (m_en[i] % UPS_T[i] == 0) begin
          md = (mode == 2'd3) ? 0 : int'(mode);
          if (md == 0) begin
            b1 = next_bit(src); src = ((src << 1) | b1) & 32'h7fff;
            b2 = next_bit(src); src = ((src << 1) | b2) & 32'h7fff;
            m_bits[i] = b1 * 2 + b2;
            l = level_of(m_bits[i]);
            m_imp[i] = 1'b0;
          end else if (md == 1) begin
            m_bits[i] = m_imp[i] ? 0 : 2;
            l = m_imp[i] ? 0 : 131071;
            m_imp[i] = 1'b1;
          end else begin
            m_bits[i] = int'(const_sel);
            l = level_of(m_bits[i]);
            m_imp[i] = 1'b0;
          end
          m_out[i] = l; m_last[i] = l; m_stb[i] = 1;
          m_cnt[i] = (m_cnt[i] + 1) % 65536;
        end else begin
          m_out[i] = (HOLD_T[i] != 0) ? m_last[i] : 0;
        end
        m_en[i]++;
      end
      m_lfsr[i] = src;
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) model_step(i);
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Single compare process: model every cycle, plus hand-computed literals requested by the stimulus.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("inst%0d sym_out", i), int'(so[i]), m_out[i]);
        check($sformatf("inst%0d sym_strobe", i), int'(ss[i]), m_stb[i]);
        check($sformatf("inst%0d bits_out", i), int'(sb[i]), m_bits[i]);
        check($sformatf("inst%0d sym_count", i), int'(sc[i]), m_cnt[i]);
      end
      if (so[1] == 18'sd131071) imp_seen++;
      case (lit_sel)
        1: begin
          if (lit_k <= 7) begin
            check($sformatf("lit prbs ups1 out k%0d", lit_k), int'(so[0]), (lit_k < 7) ? -131072 : -43690);
            check($sformatf("lit prbs ups1 bits k%0d", lit_k), int'(sb[0]), (lit_k < 7) ? 0 : 1);
            check($sformatf("lit prbs ups1 count k%0d", lit_k), int'(sc[0]), lit_k);
          end
          check($sformatf("lit ups4 strobe k%0d", lit_k), int'(ss[1]), (lit_k % 4 == 1) ? 1 : 0);
          check($sformatf("lit ups4 out k%0d", lit_k), int'(so[1]), (lit_k % 4 == 1) ? -131072 : 0);
        end
        2: check("lit const hold out", int'(so[2]), 43690);
        3: check("lit impulse pulses", imp_seen, lit_a);
        4: check($sformatf("lit seed0 out k%0d", lit_k), int'(so[0]), (lit_k < 7) ? -131072 : -43690);
        5: begin
          check("lit freeze count", int'(sc[1]), lit_a);
          check("lit freeze strobe", int'(ss[1]), 0);
        end
        6: begin
          check("lit reset out", int'(so[1]), 0);
          check("lit reset strobe", int'(ss[1]), 0);
          check("lit reset bits", int'(sb[1]), 0);
          check("lit reset count", int'(sc[0]), 0);
        end
        default: ;
      endcase
    end
  end

  task automatic tick(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lit(input int sel, input int k, input int a);
    lit_sel = sel; lit_k = k; lit_a = a;
    @(negedge clk);
    #1;
    lit_sel = 0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 2'd0; const_sel = 2'd0;
    seed_load = 1'b0; seed = 15'd0;
    tick(1);
    chk_on = 1'b1;
    tick(2);
    lit(6, 0, 0);

    // PRBS from reset, UPS=1 literal sequence and UPS=4 zero-stuff pattern
    reset = 1'b0; enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      lit(1, k, 0);
    end

    // Impulse from reset, then leave and re-enter
    reset = 1'b1; tick(2);
    reset = 1'b0; mode = 2'd1;
    tick(20);
    lit(3, 0, 1);
    mode = 2'd0; tick(8);
    mode = 2'd1; tick(20);
    lit(3, 0, 2);

    // Constant mode, HOLD instance must sit at +43690
    mode = 2'd2; const_sel = 2'd3;
    tick(8);
    for (int k = 0; k < 12; k++) begin
      tick(1);
      lit(2, k, 0);
    end
    const_sel = 2'd1; tick(9);

    // Seed of zero on a phase-0 cycle of the UPS=1 instance reproduces the post-reset sequence
    mode = 2'd0;
    reset = 1'b1; tick(2);
    reset = 1'b0; tick(5);
    seed = 15'd0; seed_load = 1'b1;
    tick(1);
    seed_load = 1'b0;
    lit(4, 1, 0);
    for (int k = 2; k <= 7; k++) begin
      tick(1);
      lit(4, k, 0);
    end
    tick(2);
    seed = 15'h4a5b; seed_load = 1'b1;
    tick(1);
    seed_load = 1'b0;
    tick(30);
    mode = 2'd3; tick(12);

    // Freeze mid-symbol: 10 enabled cycles leave UPS=4 at phase 2 with 3 symbols
    mode = 2'd0;
    reset = 1'b1; tick(2);
    reset = 1'b0;
    tick(10);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      lit(5, k, 3);
    end
    enable = 1'b1;
    tick(30);

    // Reset pulse in the middle of a symbol
    tick(2);
    reset = 1'b1; tick(1);
    reset = 1'b0; tick(20);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_symbol_source.md
TX_SYMBOL_SOURCE -- requirements
Module: tx_symbol_source

Interface
REQ-001 Parameter UPS, default 4: output samples per symbol, legal range 1..16.
REQ-002 Parameter HOLD, default 0: 0 = zero-stuff non-symbol phases; 1 = repeat the symbol on every phase.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  advances the phase counter and symbol generation when high; freezes all state when low.
REQ-006 mode  input  2  00 PRBS, 01 impulse, 10 constant, 11 treated as 00.
REQ-007 const_sel  input  2  symbol index used in constant mode.
REQ-008 seed_load  input  1  one-cycle pulse; loads seed into the LFSR.
REQ-009 seed  input  15  LFSR seed value.
REQ-010 sym_out  output  18  signed 1s17 sample to the TX pulse-shaping filter x_in.
REQ-011 sym_strobe  output  1  high on the cycle sym_out carries a new symbol (phase 0).
REQ-012 bits_out  output  2  dibit mapped into the current symbol.
REQ-013 sym_count  output  16  count of symbols emitted since reset, wraps at 65535 to 0.

Function
REQ-014 LFSR: 15-bit state s; feedback f = s[14] XOR s[13]; shift s <= {s[13:0], f}.
REQ-015 Per symbol the LFSR shifts twice; the first f is bits_out[1], the second f is bits_out[0].
REQ-016 Gray map: 00 -> -131072, 01 -> -43690, 11 -> +43690, 10 -> +131071.
REQ-017 Phase counter runs 0..UPS-1 when enable is high and wraps; a symbol is generated at phase 0.
REQ-018 sym_out, sym_strobe, bits_out and sym_count are registered, with 1-cycle latency from the sampling edge.
REQ-019 At phase 0: sym_out = mapped level; sym_strobe = 1; sym_count increments.
REQ-020 At phases other than 0: sym_out = 0 if HOLD=0, or the last symbol if HOLD=1; sym_strobe = 0.
REQ-021 When enable is low: phase, LFSR and sym_count hold; sym_out is held; sym_strobe = 0.
REQ-022 State machine PRBS/IMPULSE/CONST is selected by mode and re-evaluated at every phase 0 only; a mode change mid-symbol takes effect at the next phase 0.
REQ-023 IMPULSE, first symbol after entry: +131071 with bits_out = 10.
REQ-024 IMPULSE, subsequent symbols: sym_out = 0 with bits_out = 00; re-entering IMPULSE re-arms the single pulse.
REQ-025 CONST: each symbol equals map(const_sel); the LFSR does not shift.
REQ-026 In IMPULSE the LFSR does not shift.
REQ-027 seed_load takes priority over a shift in the same cycle; a seed of 0 is replaced by 15'h0001 (lock-up guard).
REQ-028 seed_load does not alter phase, mode state or sym_count.
REQ-029 Outputs never exceed the range [-131072, +131071]; no arithmetic beyond the mapping.

Reset
REQ-030 reset: LFSR = 15'h0001; phase = 0; state = PRBS; impulse armed.
REQ-031 reset: sym_out = 0, sym_strobe = 0, bits_out = 00, sym_count = 0.
REQ-032 reset overrides enable and seed_load.
REQ-033 Reset asserted mid-symbol aborts that symbol; the first symbol after release is produced at phase 0.

Verification
REQ-034 Check: reset, PRBS, UPS=1, enable high -> first seven sym_out values are six × -131072 then -43690 (bits 01), with sym_count 1..7.
REQ-035 Check: UPS=4, HOLD=0, PRBS -> pattern is symbol, 0, 0, 0 repeating; sym_strobe asserts every 4th cycle.
REQ-036 Check: mode=01 from reset, UPS=4 -> one +131071 then all zeros; switching to 00 and back to 01 yields exactly one more +131071.
REQ-037 Check: mode=10, const_sel=11, HOLD=1 -> sym_out constant +43690 on every cycle.
REQ-038 Check: seed_load with seed=0 -> LFSR = 0x0001, matching the post-reset sequence; seed_load coinciding with phase 0 -> loaded seed used for that shift.
REQ-039 Check: enable low for 10 cycles mid-symbol -> outputs frozen, no strobe, sequence resumes without gap or skip.
